// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its prefetch queue.
package if_pkg;

  typedef enum logic [0:0] {
    LOOKUP = 1'b0,
    FILL   = 1'b1
  } fetch_state_e;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_INST_W = 32;

  // Queue entry at the default widths; the top rebuilds it at its own widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_INST_W-1:0] inst;
  } q_entry_t;

  function automatic int unsigned nbeats(input int unsigned inst_w, input int unsigned mem_bytes);
    return inst_w / (8 * mem_bytes);
  endfunction

endpackage

// File: rtl/if_inst_queue.sv
// Synchronous FIFO for fetched instructions; head entry and its valid are registered.
module if_inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         head_valid_o,
  output logic [WIDTH-1:0]             head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             do_push_s, do_pop_s;

  // Pointer, occupancy and next-head computation; flush overrides push and pop.
  always_comb begin
    do_pop_s     = pop_i && (count_q != '0);
    do_push_s    = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop_s);
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_d       = head_q;
    head_valid_d = head_valid_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_d       = '0;
      head_valid_d = 1'b0;
    end else begin
      wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
      // The head comes from storage only when an older entry remains behind it.
      if (count_d == '0) begin
        head_d = '0;
      end else if (do_pop_s && (count_q > CNT_W'(1))) begin
        head_d = mem_q[rd_ptr_d];
      end else if (do_pop_s || (count_q == '0)) begin
        head_d = push_data_i;
      end else begin
        head_d = head_q;
      end
      head_valid_d = (count_d != '0);
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: icache lookup, narrow-port miss fill with icache write-back,
// and a prefetch queue feeding ID. Branch redirect flushes everything in flight.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned INST_W      = 32,
  parameter int unsigned MEM_BYTES   = 1,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_addr_i,
  input  logic                   id_ready_i,
  output logic                   inst_valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [ADDR_W-1:0]      pc_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [ADDR_W-1:0]      mem_a_o,
  input  logic [8*MEM_BYTES-1:0] mem_din_i,
  output logic [ADDR_W-1:0]      icache_raddr_o,
  input  logic                   icache_hit_i,
  input  logic [INST_W-1:0]      icache_inst_i,
  output logic                   icache_we_o,
  output logic [ADDR_W-1:0]      icache_waddr_o,
  output logic [INST_W-1:0]      icache_winst_o
);

  localparam int unsigned NB         = nbeats(INST_W, MEM_BYTES);
  localparam int unsigned BEAT_W     = 8 * MEM_BYTES;
  localparam int unsigned CNT_W      = $clog2(NB + 1);
  localparam int unsigned QCNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned INST_BYTES = INST_W / 8;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
  logic              pending_q, pending_d;
  logic [INST_W-1:0] fill_buf_q, fill_buf_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [INST_W-1:0] winst_q, winst_d;

  logic              push_s, pop_s, space_s, beat_acc_s, head_valid_s;
  entry_t            push_entry_s, head_s;
  logic [QCNT_W-1:0] q_count_s;

  assign space_s    = q_count_s < QCNT_W'(QUEUE_DEPTH);
  assign mem_req_o  = (state_q == FILL) && (issue_cnt_q < CNT_W'(NB));
  assign mem_a_o    = fetch_pc_q + ADDR_W'(MEM_BYTES * issue_cnt_q);
  assign beat_acc_s = mem_req_o && mem_gnt_i;
  assign pop_s      = head_valid_s && id_ready_i;

  // Fetch FSM, beat assembly and icache write-back; branch overrides all of it.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    pending_d    = 1'b0;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    winst_d      = winst_q;
    push_s       = 1'b0;
    push_entry_s = '{pc: fetch_pc_q, inst: icache_inst_i};
    // The beat returning this cycle lands in slot recv_cnt (little-endian).
    for (int i = 0; i < int'(NB); i++) begin
      fill_buf_d[i*BEAT_W +: BEAT_W] = (pending_q && (recv_cnt_q == CNT_W'(i))) ?
                                       mem_din_i : fill_buf_q[i*BEAT_W +: BEAT_W];
    end
    if (branch_flag_i) begin
      state_d     = LOOKUP;
      fetch_pc_d  = {branch_addr_i[ADDR_W-1:2], 2'b00};
      issue_cnt_d = '0;
      recv_cnt_d  = '0;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (space_s && icache_hit_i) begin
            push_s     = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
          end else if (space_s) begin
            state_d     = FILL;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
          end else begin
            state_d = LOOKUP;
          end
        end
        FILL: begin
          if (beat_acc_s) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            pending_d   = 1'b1;
          end else begin
            issue_cnt_d = issue_cnt_q;
          end
          recv_cnt_d = pending_q ? recv_cnt_q + CNT_W'(1) : recv_cnt_q;
          if (pending_q && (recv_cnt_q == CNT_W'(NB - 1))) begin
            push_s       = 1'b1;
            push_entry_s = '{pc: fetch_pc_q, inst: fill_buf_d};
            we_d         = 1'b1;
            waddr_d      = fetch_pc_q;
            winst_d      = fill_buf_d;
            fetch_pc_d   = fetch_pc_q + ADDR_W'(INST_BYTES);
            state_d      = LOOKUP;
            issue_cnt_d  = '0;
            recv_cnt_d   = '0;
          end else begin
            state_d = FILL;
          end
        end
        default: begin
          state_d = LOOKUP;
        end
      endcase
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOOKUP;
      fetch_pc_q  <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      pending_q   <= 1'b0;
      fill_buf_q  <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      winst_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      pending_q   <= pending_d;
      fill_buf_q  <= fill_buf_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      winst_q     <= winst_d;
    end
  end

  if_inst_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_s),
    .push_data_i  (push_entry_s),
    .pop_i        (pop_s),
    .flush_i      (branch_flag_i),
    .count_o      (q_count_s),
    .head_valid_o (head_valid_s),
    .head_o       (head_s)
  );

  assign inst_valid_o   = head_valid_s;
  assign inst_o         = head_s.inst;
  assign pc_o           = head_s.pc;
  assign icache_raddr_o = fetch_pc_q;
  assign icache_we_o    = we_q;
  assign icache_waddr_o = waddr_q;
  assign icache_winst_o = winst_q;

endmodule
